writeback_regfile_seq: RTL
==========================

// Module: writeback_regfile_seq
// PURPOSE
//   Write-back stage and architectural register file of the SEQ Y86-64 core. Sits directly upstream of
//   decode_seq: holds registers %rax..%r14 (IDs 0..14) and drives them to decode every cycle.
//   Commits valE/valM of the completing instruction on the clock edge, honouring Cnd for cmovXX
//   and freezing the architectural state on any non-AOK status.
// PARAMETERS
//   RESET_RSP   64'h0   value loaded into register 4 (%rsp) on reset; all other registers reset to 0
// PORTS
//   clk           in   1    core clock; all state updates on rising edge
//   rst_n         in   1    asynchronous, active-low reset
//   icode         in   4    icode of instruction completing this cycle
//   rA, rB        in   4    register specifiers from fetch (15 = RNONE)
//   Cnd           in   1    condition result from execute (cmovXX gating)
//   valE          in   64   ALU result from execute
//   valM          in   64   load data from memory stage
//   stat          in   2    instruction status: 0 AOK, 1 HLT, 2 ADR, 3 INS
//   reg_file0..14 out  64   architectural register values (15 separate ports)
//   wb_dstE       out  4    resolved E destination this cycle (15 = none)
//   wb_dstM       out  4    resolved M destination this cycle (15 = none)
//   halted        out  1    sticky: set on first non-AOK stat, cleared only by reset
// BEHAVIOUR
//   - Reset (rst_n=0, async): reg_file4=RESET_RSP, other reg_file*=0, halted=0; wb_dst* are combinational.
//   - dstE: icode 2 -> (Cnd ? rB : 15); icode 3,6 -> rB; icode 8,9,10,11 -> 4; else 15.
//   - dstM: icode 5,11 -> rA; else 15. A specifier of 15 never writes.
//   - Commit on posedge clk when stat==AOK && !halted: R[dstE]<=valE, R[dstM]<=valM.
//     Values are visible on reg_file* in the cycle after the edge (1-cycle write latency; no bypass).
//   - dstE==dstM (popq %rsp): dstM wins -> %rsp <= valM.
//   - stat!=AOK at an edge: that instruction commits nothing; halted<=1 on the same edge;
//     all later writes are blocked regardless of stat until rst_n falls.
//   - Unknown/invalid icode (0,1,12..15) with stat==AOK: no write (dstE=dstM=15).
//   - Reset asserted mid-cycle overrides any pending commit; first commit possible on the first
//     rising edge after rst_n returns high.
//   - Arithmetic: none; values stored verbatim at 64 bits.
// CONFIGURATION
//   WB_RETIRE_CNT_EN defined: adds output retire_cnt [63:0]; reset 0; +1 on each edge where
//     stat==AOK && !halted && icode in 1..11 (nop/halt-free valid instructions); wraps at 2^64-1 -> 0.
//   Not defined: port and counter absent; all other behaviour identical.
// STRUCTURE
//   - Shared package y86_pkg: icode constants (I_HALT..I_POPQ), register IDs (R_RSP=4, R_NONE=15),
//     stat codes (STAT_AOK/HLT/ADR/INS), word width constant (64).
//   - One sub-module: wb_dst_sel (combinational icode/rA/rB/Cnd -> dstE/dstM) for reuse by a later
//     PIPE implementation. Register array and halt flag stay in this module.
// TESTING
//   1. Reset with RESET_RSP=64'h100 -> reg_file4=64'h100, all others 0, halted=0.
//   2. irmovq (icode 3, rB=2, valE=64'h5, AOK) -> after edge reg_file2=5; wb_dstE=2, wb_dstM=15 during cycle.
//   3. cmovXX (icode 2, rA=1, rB=3, valE=64'h7): Cnd=0 -> reg_file3 unchanged; Cnd=1 -> reg_file3=7.
//   4. popq %rsp (icode 11, rA=4, valE=64'h108, valM=64'hAA) -> reg_file4=64'hAA.
//   5. mrmovq with stat=ADR (icode 5, rA=6, valM=1) -> reg_file6 unchanged, halted=1; following
//      irmovq rB=0 valE=9 with stat=AOK -> reg_file0 unchanged.
//   6. rst_n pulsed low between edges during an opq -> regs return to reset values immediately,
//      no commit at next edge; with WB_RETIRE_CNT_EN, retire_cnt=0 then counts 3 after 3 AOK opq.

Source files
------------

// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: instruction codes, register IDs, status codes and word width.
package y86_pkg;

  localparam int WORD_W   = 64;
  localparam int NUM_REGS = 15;

  typedef enum logic [3:0] {
    I_HALT   = 4'h0,
    I_NOP    = 4'h1,
    I_RRMOVQ = 4'h2,
    I_IRMOVQ = 4'h3,
    I_RMMOVQ = 4'h4,
    I_MRMOVQ = 4'h5,
    I_OPQ    = 4'h6,
    I_JXX    = 4'h7,
    I_CALL   = 4'h8,
    I_RET    = 4'h9,
    I_PUSHQ  = 4'hA,
    I_POPQ   = 4'hB
  } icode_e;

  typedef enum logic [1:0] {
    STAT_AOK = 2'd0,
    STAT_HLT = 2'd1,
    STAT_ADR = 2'd2,
    STAT_INS = 2'd3
  } stat_e;

  localparam logic [3:0] R_RSP  = 4'd4;
  localparam logic [3:0] R_NONE = 4'd15;

  // Instructions that count as retired: everything from nop through popq.
  function automatic logic is_retire_icode(input logic [3:0] icode);
    return (icode != I_HALT) && (icode <= I_POPQ);
  endfunction

endpackage

// File: rtl/wb_dst_sel.sv
// Combinational write-back destination resolution (dstE/dstM) from icode, specifiers and Cnd.
module wb_dst_sel
  import y86_pkg::*;
(
  input  logic [3:0] icode,
  input  logic [3:0] ra,
  input  logic [3:0] rb,
  input  logic       cnd,
  output logic [3:0] dst_e,
  output logic [3:0] dst_m
);

  // NOTE: every output gets a default first so no path through the case can infer a latch.
  always_comb begin
    dst_e = R_NONE;
    dst_m = R_NONE;
    case (icode)
      I_RRMOVQ:                     dst_e = cnd ? rb : R_NONE;
      I_IRMOVQ, I_OPQ:              dst_e = rb;
      I_CALL, I_RET, I_PUSHQ, I_POPQ: dst_e = R_RSP;
      default:                      dst_e = R_NONE;
    endcase
    if (icode == I_MRMOVQ || icode == I_POPQ) begin
      dst_m = ra;
    end
  end

endmodule

// File: rtl/writeback_regfile_seq.sv
// SEQ Y86-64 write-back stage and register file with sticky halt on non-AOK status.
// Optional macro WB_RETIRE_CNT_EN adds a 64-bit retired-instruction counter output.
module writeback_regfile_seq
  import y86_pkg::*;
#(
  parameter logic [63:0] RESET_RSP = 64'h0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        icode,
  input  logic [3:0]        rA,
  input  logic [3:0]        rB,
  input  logic              Cnd,
  input  logic [WORD_W-1:0] valE,
  input  logic [WORD_W-1:0] valM,
  input  logic [1:0]        stat,
  output logic [WORD_W-1:0] reg_file0,
  output logic [WORD_W-1:0] reg_file1,
  output logic [WORD_W-1:0] reg_file2,
  output logic [WORD_W-1:0] reg_file3,
  output logic [WORD_W-1:0] reg_file4,
  output logic [WORD_W-1:0] reg_file5,
  output logic [WORD_W-1:0] reg_file6,
  output logic [WORD_W-1:0] reg_file7,
  output logic [WORD_W-1:0] reg_file8,
  output logic [WORD_W-1:0] reg_file9,
  output logic [WORD_W-1:0] reg_file10,
  output logic [WORD_W-1:0] reg_file11,
  output logic [WORD_W-1:0] reg_file12,
  output logic [WORD_W-1:0] reg_file13,
  output logic [WORD_W-1:0] reg_file14,
  output logic [3:0]        wb_dstE,
  output logic [3:0]        wb_dstM,
`ifdef WB_RETIRE_CNT_EN
  output logic [63:0]       retire_cnt,
`endif
  output logic              halted
);

  logic [WORD_W-1:0] regs [NUM_REGS];
  logic [3:0]        dst_e;
  logic [3:0]        dst_m;
  logic              commit;

  wb_dst_sel u_dst_sel (
    .icode (icode),
    .ra    (rA),
    .rb    (rB),
    .cnd   (Cnd),
    .dst_e (dst_e),
    .dst_m (dst_m)
  );

  assign wb_dstE = dst_e;
  assign wb_dstM = dst_m;
  assign commit  = (stat == STAT_AOK) && !halted;

  // NOTE: the register file is architectural state with defined reset values, so it is reset
  // like any flop; storage without a required reset value would be left out of the reset branch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= (i == int'(R_RSP)) ? RESET_RSP : '0;
      end
    end else if (commit) begin
      // dstM is tested first so popq %rsp takes the loaded value over the incremented pointer.
      for (int i = 0; i < NUM_REGS; i++) begin
        if (dst_m == 4'(i)) begin
          regs[i] <= valM;
        end else if (dst_e == 4'(i)) begin
          regs[i] <= valE;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      halted <= 1'b0;
    end else if (stat != STAT_AOK) begin
      halted <= 1'b1;
    end
  end

`ifdef WB_RETIRE_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retire_cnt <= '0;
    end else if (commit && is_retire_icode(icode)) begin
      retire_cnt <= retire_cnt + 64'd1;
    end
  end
`endif

  assign reg_file0  = regs[0];
  assign reg_file1  = regs[1];
  assign reg_file2  = regs[2];
  assign reg_file3  = regs[3];
  assign reg_file4  = regs[4];
  assign reg_file5  = regs[5];
  assign reg_file6  = regs[6];
  assign reg_file7  = regs[7];
  assign reg_file8  = regs[8];
  assign reg_file9  = regs[9];
  assign reg_file10 = regs[10];
  assign reg_file11 = regs[11];
  assign reg_file12 = regs[12];
  assign reg_file13 = regs[13];
  assign reg_file14 = regs[14];

endmodule
